// File: rtl/spi_pmod_pkg.sv
// Shared constants for the PMOD SPI responder: FSM encoding and default frame widths
// (the widths also appear in the master's C-side register map).
package spi_pmod_pkg;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;

  localparam int RX_BITS_DEF = 24;
  localparam int TX_BITS_DEF = 16;
endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one SPI pin, followed by an edge-detect register
// that produces single-cycle rise/fall pulses.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      s1   <= pin;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;
endmodule

// File: rtl/spi_pmod_responder.sv
// Device end of the PMOD SPI link: oversamples SCK/SDI/CONV_CS, deserialises SDI
// MSB-first and serialises a preloaded response word onto SDO MSB-first.
module spi_pmod_responder
  import spi_pmod_pkg::*;
#(
  parameter int RX_BITS = RX_BITS_DEF,
  parameter int TX_BITS = TX_BITS_DEF,
  parameter int CNT_W   = 6
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  input  logic               SCK,
  input  logic               SDI,
  input  logic               CONV_CS,
  output logic               SDO,
  input  logic [TX_BITS-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  output logic [CNT_W-1:0]   rx_bit_count,
  output logic               frame_error,
  output logic               tx_underrun,
  output logic               busy
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_BITS);

  logic sck_rise, sck_fall, sdi_s, cs_s, cs_rise, cs_fall;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sck (
    .S_AXI_ACLK, .S_AXI_ARESET, .pin(SCK), .level(), .rise(sck_rise), .fall(sck_fall));
  spi_pin_sync #(.RST_VAL(1'b0)) u_sdi (
    .S_AXI_ACLK, .S_AXI_ARESET, .pin(SDI), .level(sdi_s), .rise(), .fall());
  spi_pin_sync #(.RST_VAL(1'b1)) u_cs (
    .S_AXI_ACLK, .S_AXI_ARESET, .pin(CONV_CS), .level(cs_s), .rise(cs_rise), .fall(cs_fall));

  logic [1:0]         state;
  logic [1:0]         settle;
  logic               hold_full;
  logic [TX_BITS-1:0] hold_data, tx_sh, tx_sh_nx;
  logic [RX_BITS-1:0] rx_sh, rx_sh_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  assign tx_ready = ~hold_full;
  assign busy     = (state == ST_ACTIVE);

  // Edge effects computed up front so a CS rise in the same cycle closes on updated values.
  always_comb begin
    rx_sh_nx = rx_sh;
    cnt_nx   = cnt;
    tx_sh_nx = tx_sh;
    if (sck_rise) begin
      rx_sh_nx = {rx_sh[RX_BITS-2:0], sdi_s};
      cnt_nx   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
    if (sck_fall) tx_sh_nx = {tx_sh[TX_BITS-2:0], 1'b0};
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state        <= ST_WAIT_IDLE;
      settle       <= '0;
      hold_full    <= 1'b0;
      hold_data    <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      cnt          <= '0;
      SDO          <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_bit_count <= '0;
      frame_error  <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      tx_underrun <= 1'b0;
      SDO         <= (state == ST_ACTIVE) & tx_sh[TX_BITS-1];

      if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end

      case (state)
        // The CS synchroniser shows its reset value for a few cycles; wait for real pin samples.
        ST_WAIT_IDLE: begin
          if (settle != 2'd3) settle <= settle + 1'b1;
          else if (cs_s)      state  <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cs_fall) begin
            rx_sh <= '0;
            cnt   <= '0;
            state <= ST_ACTIVE;
            if (hold_full) begin
              tx_sh     <= hold_data;
              hold_full <= 1'b0;
            end else begin
              tx_sh       <= '0;
              tx_underrun <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          rx_sh <= rx_sh_nx;
          cnt   <= cnt_nx;
          tx_sh <= tx_sh_nx;
          if (cs_rise) begin
            rx_bit_count <= cnt_nx;
            if (cnt_nx == CNT_FULL) begin
              rx_data  <= rx_sh_nx;
              rx_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_pmod_responder.md
Name: spi_pmod_responder

Overview:
- SPI peripheral-side responder: the device end of the PMOD ADC/DAC link, driven by the team's AXI4-Lite SPI master (SCK, SDI, CONV_CS out; SDO in).
- Oversamples the master's pins on the system clock and deserialises the SDI frame MSB-first; serialises a preloaded response word onto SDO MSB-first.
- Used as an on-chip loopback/stand-in device for master bring-up and as a protocol checker.

Parameters:
- RX_BITS, 24, SDI bits per complete frame.
- TX_BITS, 16, SDO response word width.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W-1 > RX_BITS.

Ports:
- S_AXI_ACLK  in  1  system clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- SCK  in  1  shift clock from master; idle low; each half period is at least 3 S_AXI_ACLK cycles.
- SDI  in  1  serial data from master.
- CONV_CS  in  1  frame select; active low.
- SDO  out  1  serial response to master.
- tx_data  in  TX_BITS  response word for the next frame.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  holding register empty.
- rx_data  out  RX_BITS  last complete frame, MSB = first bit received.
- rx_valid  out  1  one-cycle pulse; rx_data updated.
- rx_bit_count  out  CNT_W  SCK rising edges in the last frame, saturating.
- frame_error  out  1  one-cycle pulse; frame ended with count != RX_BITS.
- tx_underrun  out  1  one-cycle pulse; frame started with an empty holding register.
- busy  out  1  high while in state ACTIVE.

Behaviour:
- Reset values: SDO=0, tx_ready=1, rx_data=0, rx_valid=0, rx_bit_count=0, frame_error=0, tx_underrun=0, busy=0, holding register empty, state=WAIT_IDLE.
- Synchronisers: SCK, SDI and CONV_CS each pass through 2 flops, then one edge-detect register. CONV_CS sync flops reset to 1; SCK and SDI sync flops reset to 0. An edge acts on internal state 3 cycles after the pin change. SDO is registered, so it changes 4 cycles after the pin change.
- Holding register: loads tx_data when tx_valid && tx_ready. tx_ready=0 while full. It empties only when a CS fall transfers it into the TX shift register.
- FSM WAIT_IDLE: ignores all edges. Moves to IDLE when synchronised CS=1. This prevents arming mid-frame after reset.
- FSM IDLE: SDO=0. On a CS fall:
  - clear the RX shift register and the bit counter;
  - if the holding register is full, load the TX shift register from it, free the holding register and drive SDO = holding MSB;
  - otherwise load the TX shift register with zeros and pulse tx_underrun;
  - go to ACTIVE.
- FSM ACTIVE, SCK rise: shift the synchronised SDI into the RX shift register LSB; counter += 1, saturating at 2^CNT_W-1. Once more than RX_BITS bits arrive, the register keeps the last RX_BITS bits.
- FSM ACTIVE, SCK fall: shift the TX register left with zero fill; SDO = new MSB. After TX_BITS falls SDO stays 0.
- FSM ACTIVE, CS rise: rx_bit_count = counter.
  - If counter == RX_BITS: rx_data = shift register and pulse rx_valid.
  - Otherwise: pulse frame_error and leave rx_data unchanged.
  - SDO=0; go to IDLE.
- Same-cycle CS fall and tx_valid with an empty holding register: no bypass. tx_underrun pulses and the new word is held for the following frame.
- CS rise in the same cycle as an SCK edge: the edge is processed first, then the frame closes.
- SCK edges while CS is high are ignored.
- Asynchronous reset mid-frame clears everything and returns to WAIT_IDLE.

Decomposition:
- Shared package spi_pmod_pkg holds:
  - the FSM state encoding (WAIT_IDLE=0, IDLE=1, ACTIVE=2);
  - default frame-width constants (24 RX, 16 TX), shared with the master's C-side register map.
- One sub-module, spi_pin_sync: 2-flop synchroniser plus rise/fall pulse outputs, with a reset-value parameter. It is instantiated three times.

Test Plan:
- Load tx_data=16'hA5C3. Master-model frame: 24 SCK cycles, half period 3 clocks, SDI=24'h123456. Required: rx_valid pulse with rx_data=24'h123456, rx_bit_count=24. Master samples 16'hA5C3 then 8 zero bits.
- No tx_valid before CS fall, SDI=24'hFFFFFF. Required: tx_underrun pulses once, SDO=0 throughout, rx_valid with rx_data=24'hFFFFFF.
- Frame of 20 SCK cycles. Required: frame_error pulse, rx_bit_count=20, rx_valid absent, rx_data holds the previous value.
- Two back-to-back frames with tx_data 16'h0001 then 16'h8000 offered during frame 1. Required: tx_ready drops after the second offer; frame 2 returns 16'h8000.
- Assert reset at SCK edge 10 while CS low; release with CS still low. Required: no activity and no pulses until CS goes high then low again; the next full frame decodes correctly.
- Toggle SCK 5 times with CS high. Required: counter stays 0, SDO=0, no pulses.
